// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and constants for the interrupt controller and its sub-blocks.
package interrupt_ctrl_pkg;

    localparam int          INT_NUM_SRC  = 4;
    localparam logic [31:0] INT_VEC_BASE = 32'h0600_FF00;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        VECTOR,
        SERVICE,
        RESTORE
    } int_state_t;

    // Each source owns a 16-byte slot above the vector base.
    function automatic logic [31:0] vec_addr(input logic [1:0] id);
        return INT_VEC_BASE + {26'd0, id, 4'b0000};
    endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Pipeline-facing signal bundle between the interrupt controller and the core.
interface interrupt_ctrl_if;

    logic        int_allow;
    logic        rin_retire;
    logic [31:0] resume_PC;
    logic [31:0] LR;
    logic [1:0]  FL;
    logic        flush;
    logic        PC_redirect;
    logic [31:0] PC_target;
    logic        restore;
    logic [31:0] LR_before_int;
    logic [1:0]  FL_before_int;

    // The controller commands flushes and redirects; the pipeline reports its status.
    modport master (
        input  int_allow, rin_retire, resume_PC, LR, FL,
        output flush, PC_redirect, PC_target, restore, LR_before_int, FL_before_int
    );

    modport slave (
        output int_allow, rin_retire, resume_PC, LR, FL,
        input  flush, PC_redirect, PC_target, restore, LR_before_int, FL_before_int
    );

endinterface

// File: rtl/interrupt_ctrl_prio_enc.sv
// Fixed-priority 4-to-2 encoder; bit 0 wins, valid is low when no bit is set.
module int_prio_enc (
    input  logic [3:0] req,
    output logic [1:0] id,
    output logic       valid
);

    always_comb begin
        id    = 2'd0;
        valid = 1'b1;
        if (req[0])      id = 2'd0;
        else if (req[1]) id = 2'd1;
        else if (req[2]) id = 2'd2;
        else if (req[3]) id = 2'd3;
        else             valid = 1'b0;
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Non-nesting interrupt controller: flush, vector, service, restore.
// Define INT_MASK_EN to add the writable per-source enable mask.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INT_NUM_SRC-1:0] irq_req,
`ifdef INT_MASK_EN
    input  logic                   mask_wr,
    input  logic [INT_NUM_SRC-1:0] mask_data,
`endif
    interrupt_ctrl_if.master       bus,
    output logic                   in_service,
    output logic [1:0]             irq_id
);

    int_state_t             state;
    logic [INT_NUM_SRC-1:0] pending;
    logic [INT_NUM_SRC-1:0] enabled;
    logic [INT_NUM_SRC-1:0] pend_eff;
    logic [INT_NUM_SRC-1:0] candidates;
    logic [INT_NUM_SRC-1:0] win_onehot;
    logic [1:0]             win_id;
    logic                   win_valid;
    logic                   accept;
    logic [31:0]            saved_PC;

`ifdef INT_MASK_EN
    logic [INT_NUM_SRC-1:0] mask;

    always_ff @(posedge clk) begin
        if (rst)          mask <= '1;
        else if (mask_wr) mask <= mask_data;
    end

    assign enabled = mask;
`else
    assign enabled = '1;
`endif

    // A request arriving this cycle is eligible immediately, so entry costs one edge.
    assign pend_eff   = pending | irq_req;
    assign candidates = pend_eff & enabled;

    int_prio_enc u_prio_enc (
        .req   (candidates),
        .id    (win_id),
        .valid (win_valid)
    );

    assign accept     = (state == IDLE) && bus.int_allow && win_valid;
    assign win_onehot = accept ? (4'b0001 << win_id) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pending           <= '0;
            irq_id            <= 2'd0;
            saved_PC          <= 32'd0;
            in_service        <= 1'b0;
            bus.flush         <= 1'b0;
            bus.PC_redirect   <= 1'b0;
            bus.PC_target     <= 32'd0;
            bus.restore       <= 1'b0;
            bus.LR_before_int <= 32'd0;
            bus.FL_before_int <= 2'd0;
        end else begin
            pending <= pend_eff & ~win_onehot;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= FLUSH;
                        irq_id     <= win_id;
                        in_service <= 1'b1;
                        bus.flush  <= 1'b1;
                    end
                end
                FLUSH: begin
                    saved_PC          <= bus.resume_PC;
                    bus.LR_before_int <= bus.LR;
                    bus.FL_before_int <= bus.FL;
                    bus.flush         <= 1'b0;
                    bus.PC_redirect   <= 1'b1;
                    bus.PC_target     <= vec_addr(irq_id);
                    state             <= VECTOR;
                end
                VECTOR: begin
                    bus.PC_redirect <= 1'b0;
                    bus.PC_target   <= 32'd0;
                    state           <= SERVICE;
                end
                SERVICE: begin
                    if (bus.rin_retire) begin
                        bus.restore     <= 1'b1;
                        bus.flush       <= 1'b1;
                        bus.PC_redirect <= 1'b1;
                        bus.PC_target   <= saved_PC;
                        state           <= RESTORE;
                    end
                end
                RESTORE: begin
                    bus.restore     <= 1'b0;
                    bus.flush       <= 1'b0;
                    bus.PC_redirect <= 1'b0;
                    bus.PC_target   <= 32'd0;
                    in_service      <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed self-checking bench for interrupt_ctrl; mask scenario runs only with INT_MASK_EN.
module tb_interrupt_ctrl;
    import interrupt_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_req;
    logic       in_service;
    logic [1:0] irq_id;
`ifdef INT_MASK_EN
    logic       mask_wr;
    logic [3:0] mask_data;
`endif

    interrupt_ctrl_if bus();

    int checks = 0;
    int errors = 0;

    // Control snapshot: {flush, PC_redirect, restore, in_service}.
    wire [3:0] ctl = {bus.flush, bus.PC_redirect, bus.restore, in_service};

    always #5 clk = ~clk;

    interrupt_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_req    (irq_req),
`ifdef INT_MASK_EN
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
`endif
        .bus        (bus),
        .in_service (in_service),
        .irq_id     (irq_id)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Walks a handler from FLUSH back to IDLE without checking.
    task automatic finish_handler();
        irq_req = 4'b0000;
        step(2);
        bus.rin_retire = 1'b1;
        step();
        bus.rin_retire = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ctl got %b expected 0000", ctl); end
        checks++; if (bus.PC_target !== 32'd0) begin errors++; $display("[TB] FAIL reset_target got %h expected 0", bus.PC_target); end
        checks++; if ({bus.LR_before_int, bus.FL_before_int} !== 34'd0) begin errors++; $display("[TB] FAIL reset_saved got %h/%b expected 0", bus.LR_before_int, bus.FL_before_int); end
        checks++; if (irq_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id got %0d expected 0", irq_id); end
        rst = 1'b0;
        bus.int_allow = 1'b1;
        step(2);
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL reset_idle got %b expected 0000", ctl); end
    endtask

    task automatic test_basic_entry();
        bus.resume_PC = 32'h0600_0040;
        bus.LR        = 32'h0000_1234;
        bus.FL        = 2'b10;
        bus.int_allow = 1'b1;
        irq_req       = 4'b0100;
        step();
        irq_req = 4'b0000;
        checks++; if (ctl !== 4'b1001) begin errors++; $display("[TB] FAIL entry_flush got %b expected 1001", ctl); end
        checks++; if (irq_id !== 2'd2) begin errors++; $display("[TB] FAIL entry_id got %0d expected 2", irq_id); end
        step();
        checks++; if (ctl !== 4'b0101) begin errors++; $display("[TB] FAIL vector_ctl got %b expected 0101", ctl); end
        checks++; if (bus.PC_target !== 32'h0600_FF20) begin errors++; $display("[TB] FAIL vector_target got %h expected 0600ff20", bus.PC_target); end
        checks++; if (bus.LR_before_int !== 32'h0000_1234) begin errors++; $display("[TB] FAIL saved_lr got %h expected 00001234", bus.LR_before_int); end
        checks++; if (bus.FL_before_int !== 2'b10) begin errors++; $display("[TB] FAIL saved_fl got %b expected 10", bus.FL_before_int); end
        step(3);
        checks++; if ({ctl, bus.PC_target} !== {4'b0001, 32'd0}) begin errors++; $display("[TB] FAIL service_hold got %b/%h expected 0001/0", ctl, bus.PC_target); end
    endtask

    task automatic test_return();
        bus.resume_PC  = 32'h0600_0100;
        bus.rin_retire = 1'b1;
        step();
        bus.rin_retire = 1'b0;
        checks++; if (ctl !== 4'b1111) begin errors++; $display("[TB] FAIL restore_ctl got %b expected 1111", ctl); end
        checks++; if (bus.PC_target !== 32'h0600_0040) begin errors++; $display("[TB] FAIL restore_target got %h expected 06000040", bus.PC_target); end
        step();
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL return_idle got %b expected 0000", ctl); end
        checks++; if (bus.PC_target !== 32'd0) begin errors++; $display("[TB] FAIL return_target got %h expected 0", bus.PC_target); end
    endtask

    task automatic test_priority();
        irq_req = 4'b1010;
        step();
        irq_req = 4'b0000;
        checks++; if ({ctl, irq_id} !== {4'b1001, 2'd1}) begin errors++; $display("[TB] FAIL prio_first got %b/%0d expected 1001/1", ctl, irq_id); end
        bus.rin_retire = 1'b1;
        step();
        checks++; if (bus.PC_target !== 32'h0600_FF10) begin errors++; $display("[TB] FAIL prio_target1 got %h expected 0600ff10", bus.PC_target); end
        step();
        bus.rin_retire = 1'b0;
        step();
        checks++; if ({ctl, bus.PC_target} !== {4'b0001, 32'd0}) begin errors++; $display("[TB] FAIL rin_ignored got %b/%h expected 0001/0", ctl, bus.PC_target); end
        bus.rin_retire = 1'b1;
        step();
        bus.rin_retire = 1'b0;
        checks++; if (ctl !== 4'b1111) begin errors++; $display("[TB] FAIL prio_restore got %b expected 1111", ctl); end
        step();
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL prio_gap got %b expected 0000", ctl); end
        step();
        checks++; if ({ctl, irq_id} !== {4'b1001, 2'd3}) begin errors++; $display("[TB] FAIL prio_second got %b/%0d expected 1001/3", ctl, irq_id); end
        step();
        checks++; if (bus.PC_target !== 32'h0600_FF30) begin errors++; $display("[TB] FAIL prio_target3 got %h expected 0600ff30", bus.PC_target); end
        step();
        bus.rin_retire = 1'b1;
        step();
        bus.rin_retire = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        irq_req        = 4'b0001;
        bus.rin_retire = 1'b1;
        step();
        bus.rin_retire = 1'b0;
        checks++; if ({ctl, irq_id} !== {4'b1001, 2'd0}) begin errors++; $display("[TB] FAIL req_with_rin got %b/%0d expected 1001/0", ctl, irq_id); end
        finish_handler();
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL req_with_rin_done got %b expected 0000", ctl); end
    endtask

    task automatic test_blocking();
        bus.int_allow = 1'b0;
        irq_req       = 4'b0010;
        step();
        irq_req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL blocked_%0d got %b expected 0000", i, ctl); end
            step();
        end
        bus.int_allow = 1'b1;
        step();
        checks++; if ({ctl, irq_id} !== {4'b1001, 2'd1}) begin errors++; $display("[TB] FAIL unblocked got %b/%0d expected 1001/1", ctl, irq_id); end
        finish_handler();
    endtask

    task automatic test_reset_mid_service();
        irq_req = 4'b1000;
        step();
        irq_req = 4'b0000;
        step(2);
        irq_req = 4'b0100;
        step();
        irq_req = 4'b0000;
        checks++; if (ctl !== 4'b0001) begin errors++; $display("[TB] FAIL pre_reset_service got %b expected 0001", ctl); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({ctl, bus.PC_target} !== {4'b0000, 32'd0}) begin errors++; $display("[TB] FAIL mid_reset_out got %b/%h expected 0000/0", ctl, bus.PC_target); end
        checks++; if ({irq_id, bus.LR_before_int, bus.FL_before_int} !== 36'd0) begin errors++; $display("[TB] FAIL mid_reset_regs got %0d/%h/%b expected 0", irq_id, bus.LR_before_int, bus.FL_before_int); end
        step();
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset_pending got %b expected 0000", ctl); end
        step();
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset_quiet got %b expected 0000", ctl); end
    endtask

`ifdef INT_MASK_EN
    task automatic test_mask();
        mask_data = 4'b1110;
        mask_wr   = 1'b1;
        step();
        mask_wr = 1'b0;
        irq_req = 4'b0001;
        step();
        irq_req = 4'b0000;
        step(2);
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL masked_entry got %b expected 0000", ctl); end
        mask_data = 4'b1111;
        mask_wr   = 1'b1;
        step();
        mask_wr = 1'b0;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL mask_write_cycle got %b expected 0000", ctl); end
        step();
        checks++; if ({ctl, irq_id} !== {4'b1001, 2'd0}) begin errors++; $display("[TB] FAIL unmasked_entry got %b/%0d expected 1001/0", ctl, irq_id); end
        finish_handler();
    endtask
`endif

    initial begin
        rst            = 1'b1;
        irq_req        = 4'b0000;
        bus.int_allow  = 1'b0;
        bus.rin_retire = 1'b0;
        bus.resume_PC  = 32'd0;
        bus.LR         = 32'd0;
        bus.FL         = 2'd0;
`ifdef INT_MASK_EN
        mask_wr        = 1'b0;
        mask_data      = 4'b1111;
`endif
        test_reset();
        test_basic_entry();
        test_return();
        test_priority();
        test_back_to_back();
        test_blocking();
        test_reset_mid_service();
`ifdef INT_MASK_EN
        test_mask();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
